// File: rtl/td4_core_param.sv
// TD4-class accumulator CPU: one instruction per enabled clock, fetched from external ROM at address=PC.
// Optional macro TD4_HALT_EN turns opcode 1000 into HLT; otherwise it is a NOP and halted is tied 0.
module td4_core_param #(
  parameter  int DW = 4,
  parameter  int AW = 4,
  localparam int IW = 4 + DW
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          en,
  input  logic [IW-1:0] instr,
  output logic [AW-1:0] address,
  input  logic [DW-1:0] in_port,
  output logic [DW-1:0] out_port,
  output logic          out_strobe,
  output logic          halted
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_MV_AB = 4'b0001;
  localparam logic [3:0] OP_MV_BA = 4'b0100;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1111;
  localparam logic [3:0] OP_JNC   = 4'b1110;
`ifdef TD4_HALT_EN
  localparam logic [3:0] OP_HLT   = 4'b1000;
`endif

  logic [3:0]    opcode;
  logic [DW-1:0] im;
  logic [DW-1:0] src;
  logic [DW:0]   sum;
  logic          wr_a, wr_b, wr_out, take_jmp, hlt, run;

  logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          cf_q, cf_d, strb_q, strb_d;
  logic          halted_q, halted_d;

  assign opcode = instr[IW-1:IW-4];
  assign im     = instr[DW-1:0];

  // Decode: pick ALU source and destination; undefined opcodes add 0+im so carry is always clear.
  always_comb begin
    src      = '0;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    wr_out   = 1'b0;
    take_jmp = 1'b0;
    hlt      = 1'b0;
    case (opcode)
      OP_ADD_A: begin src = a_q;     wr_a = 1'b1; end
      OP_ADD_B: begin src = b_q;     wr_b = 1'b1; end
      OP_MOV_A: wr_a = 1'b1;
      OP_MOV_B: wr_b = 1'b1;
      OP_MV_AB: begin src = b_q;     wr_a = 1'b1; end
      OP_MV_BA: begin src = a_q;     wr_b = 1'b1; end
      OP_IN_A:  begin src = in_port; wr_a = 1'b1; end
      OP_IN_B:  begin src = in_port; wr_b = 1'b1; end
      OP_OUT_B: begin src = b_q;     wr_out = 1'b1; end
      OP_OUT_I: wr_out = 1'b1;
      OP_JMP:   take_jmp = 1'b1;
      OP_JNC:   take_jmp = ~cf_q;
`ifdef TD4_HALT_EN
      OP_HLT:   hlt = 1'b1;
`endif
      default:  ;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, im};

`ifdef TD4_HALT_EN
  assign run = en & ~halted_q;
`else
  assign run = en;
`endif

  // Next state: everything holds unless an instruction executes; the strobe always falls.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    pc_d     = pc_q;
    cf_d     = cf_q;
    strb_d   = 1'b0;
    halted_d = halted_q;
    if (run) begin
      if (hlt) begin
        halted_d = 1'b1;
      end else begin
        cf_d   = sum[DW];
        strb_d = wr_out;
        pc_d   = take_jmp ? im[AW-1:0] : pc_q + AW'(1);
        if (wr_a)   a_d   = sum[DW-1:0];
        if (wr_b)   b_d   = sum[DW-1:0];
        if (wr_out) out_d = sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      pc_q   <= '0;
      cf_q   <= 1'b0;
      strb_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      pc_q   <= pc_d;
      cf_q   <= cf_d;
      strb_q <= strb_d;
    end
  end

`ifdef TD4_HALT_EN
  always_ff @(posedge clk) begin
    if (!n_reset) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign address    = pc_q;
  assign out_port   = out_q;
  assign out_strobe = strb_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_td4_core_param.sv
// Self-checking bench for td4_core_param (DW=AW=4): instruction-level model plus directed programs.
module tb_td4_core_param;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] instr;
  logic [3:0] address;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port;
  logic       out_strobe;
  logic       halted;
  logic [7:0] rom [16];

  assign instr = rom[address];

  td4_core_param #(.DW(4), .AW(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .en        (en),
    .instr     (instr),
    .address   (address),
    .in_port   (in_port),
    .out_port  (out_port),
    .out_strobe(out_strobe),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int pc; int cf; int outp; int strb; int halt;
  } st_t;

  st_t m = '{default: 0};
  int  n_chk = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;

  // Architectural effect of one clock edge, written from the instruction set table.
  function automatic st_t next_st(st_t s, logic rst_n, logic e, int inp, int ins);
    st_t n = s;
    int op = ins / 16;
    int im = ins % 16;
    int r;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    n.strb = 0;
    if (!e || s.halt != 0) return n;
`ifdef TD4_HALT_EN
    if (op == 8) begin
      n.halt = 1;
      return n;
    end
`endif
    n.cf = 0;
    case (op)
      0:  begin r = s.a + im; n.a = r % 16; n.cf = r / 16; end
      5:  begin r = s.b + im; n.b = r % 16; n.cf = r / 16; end
      3:  n.a = im;
      7:  n.b = im;
      1:  begin r = s.b + im; n.a = r % 16; n.cf = r / 16; end
      4:  begin r = s.a + im; n.b = r % 16; n.cf = r / 16; end
      2:  begin r = inp + im; n.a = r % 16; n.cf = r / 16; end
      6:  begin r = inp + im; n.b = r % 16; n.cf = r / 16; end
      9:  begin r = s.b + im; n.outp = r % 16; n.cf = r / 16; n.strb = 1; end
      11: begin n.outp = im; n.strb = 1; end
      default: ;
    endcase
    if (op == 15 || (op == 14 && s.cf == 0)) n.pc = im;
    else                                      n.pc = (s.pc + 1) % 16;
    return n;
  endfunction

  always @(posedge clk) m <= next_st(m, n_reset, en, int'(in_port), int'(rom[m.pc]));

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    step(2);
    n_reset = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    clear_rom();
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE9; rom[3] = 8'h90;
    en = 1'b1;
    do_reset();
    check("rst_address", 32'(address), 0);
    check("rst_out_port", 32'(out_port), 0);
    check("rst_strobe", 32'(out_strobe), 0);
    check("rst_halted", 32'(halted), 0);
    chk_on = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          check("model_address", 32'(address), m.pc);
          check("model_out_port", 32'(out_port), m.outp);
          check("model_strobe", 32'(out_strobe), m.strb);
          check("model_halted", 32'(halted), m.halt);
        end
      end
    join_none

    // JNC not taken after an overflowing ADD
    step(); check("jnc_nt_addr1", 32'(address), 1);
    step(); check("jnc_nt_addr2", 32'(address), 2);
    step(); check("jnc_nt_addr3", 32'(address), 3);
    step(); check("out_b_strobe", 32'(out_strobe), 1);

    // JNC taken when carry is clear
    rom[1] = 8'h01;
    do_reset();
    step(3); check("jnc_taken_addr", 32'(address), 9);

    // IN / MOV B,A / OUT B+1
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h91;
    in_port = 4'hA;
    do_reset();
    step(3);
    check("io_out_port", 32'(out_port), 11);
    check("io_strobe_hi", 32'(out_strobe), 1);
    step();
    check("io_strobe_lo", 32'(out_strobe), 0);
    check("io_out_hold", 32'(out_port), 11);

    // PC wrap 15 -> 0, then JMP 7
    clear_rom();
    rom[0] = 8'hFF; rom[15] = 8'hB5;
    do_reset();
    step(); check("wrap_addr15", 32'(address), 15);
    step(); check("wrap_addr0", 32'(address), 0);
    check("wrap_out_port", 32'(out_port), 5);
    rom[0] = 8'hF7;
    step(); check("jmp7_addr", 32'(address), 7);

    // back-to-back OUTs, then enable gap
    for (int i = 0; i < 16; i++) rom[i] = 8'hB0 | 8'(i);
    do_reset();
    step(2);
    check("b2b_out1", 32'(out_port), 1);
    check("b2b_strobe", 32'(out_strobe), 1);
    step();
    check("pre_en_addr", 32'(address), 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_addr", 32'(address), 3);
      check("en0_out_port", 32'(out_port), 2);
      check("en0_strobe", 32'(out_strobe), 0);
    end
    en = 1'b1;
    step();
    check("resume_addr", 32'(address), 4);
    check("resume_out_port", 32'(out_port), 3);
    check("resume_strobe", 32'(out_strobe), 1);

    // IN B overflow sets carry; the not-taken JNC then clears it
    clear_rom();
    rom[0] = 8'h6F; rom[1] = 8'hE5; rom[2] = 8'hE5;
    in_port = 4'h3;
    do_reset();
    step(2); check("inb_cf_jnc_nt", 32'(address), 2);
    step();  check("inb_jnc_taken", 32'(address), 5);

    // HLT (or NOP in the default build) at address 2
    clear_rom();
    rom[2] = 8'h80;
    do_reset();
    step(2); check("pre_hlt_addr", 32'(address), 2);
    step();
`ifdef TD4_HALT_EN
    check("hlt_halted", 32'(halted), 1);
    check("hlt_addr", 32'(address), 2);
    step(3);
    check("hlt_stuck_addr", 32'(address), 2);
    check("hlt_stuck_halted", 32'(halted), 1);
`else
    check("nop_addr", 32'(address), 3);
    check("nop_halted", 32'(halted), 0);
`endif
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    check("post_rst_halted", 32'(halted), 0);
    check("post_rst_addr", 32'(address), 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
